// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Operands are registered into the ALU and its result is registered back out.
module alu_rr_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_res,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_res,
  output logic              rsp1_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_zero,
  output logic [CNT_W-1:0]  op_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                zero_q, zero_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic [CNT_W-1:0]    op_cnt_q, op_cnt_d;

  logic any_req;
  logic grant;
  logic accept;
  logic rsp_fire;

  // With both requesting, the one not served last wins; otherwise the lone requester.
  always_comb begin
    any_req    = req0_valid | req1_valid;
    grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    req0_ready = (state_q == IDLE) && any_req && (grant == 1'b0);
    req1_ready = (state_q == IDLE) && any_req && (grant == 1'b1);
    accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    rsp_fire   = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    res_d        = res_q;
    zero_d       = zero_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    op_cnt_d     = op_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d  = grant;
          alu_a_d  = grant ? req1_a  : req0_a;
          alu_b_d  = grant ? req1_b  : req0_b;
          alu_op_d = grant ? req1_op : req0_op;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        res_d        = alu_res;
        zero_d       = alu_zero;
        rsp0_valid_d = ~owner_q;
        rsp1_valid_d = owner_q;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_fire) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          last_grant_d = owner_q;
          op_cnt_d     = op_cnt_q + CNT_W'(1);
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // last_grant resets to 1 so requester 0 wins the first contended cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      res_q        <= '0;
      zero_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      op_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      res_q        <= res_d;
      zero_q       <= zero_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      op_cnt_q     <= op_cnt_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_res   = res_q;
  assign rsp1_res   = res_q;
  assign rsp0_zero  = zero_q;
  assign rsp1_zero  = zero_q;
  assign op_cnt     = op_cnt_q;

  // Structural invariants of the arbiter: one grant and one response owner at most.
  a_one_ready : assert property (@(posedge clk) disable iff (!rst_n) !(req0_ready && req1_ready));
  a_one_rsp   : assert property (@(posedge clk) disable iff (!rst_n) !(rsp0_valid_q && rsp1_valid_q));

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: a small ALU model closes the loop and every
// expected value is written out by hand or derived from the operands.
module tb_alu_rr_arbiter;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OP_W-1:0]   req0_op, req1_op;
  logic              rsp0_valid, rsp1_valid;
  logic              rsp0_ready, rsp1_ready;
  logic [DATA_W-1:0] rsp0_res, rsp1_res;
  logic              rsp0_zero, rsp1_zero;
  logic [DATA_W-1:0] alu_a, alu_b, alu_res;
  logic [OP_W-1:0]   alu_op;
  logic              alu_zero;
  logic [CNT_W-1:0]  op_cnt;

  int compared;
  int mismatched;
  int cycleCnt;
  int grantWho[$];
  int grantCyc[$];
  bit sawRsp;

  // Small counter width so the wrap can be reached in a short run.
  alu_rr_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_res(rsp0_res), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_res(rsp1_res), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_zero(alu_zero),
    .op_cnt(op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      4'd0:    alu_res = alu_a & alu_b;
      4'd1:    alu_res = alu_a | alu_b;
      4'd2:    alu_res = alu_a + alu_b;
      4'd6:    alu_res = alu_a - alu_b;
      4'd7:    alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_res = alu_a ^ alu_b;
    endcase
    alu_zero = (alu_res == 32'd0);
  end

  // Log every request handshake with its cycle number.
  always @(posedge clk) begin
    cycleCnt = cycleCnt + 1;
    if (req0_valid && req0_ready) begin
      grantWho.push_back(0);
      grantCyc.push_back(cycleCnt);
    end
    if (req1_valid && req1_ready) begin
      grantWho.push_back(1);
      grantCyc.push_back(cycleCnt);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared = compared + 1;
    if (observed !== expected) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit who, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    if (who) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #3;
    checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_alu_b", alu_b, 32'd0);
    checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
    checkOutput("rst_res", rsp0_res, 32'd0);
    checkOutput("rst_zero", 32'(rsp0_zero), 32'd0);
    checkOutput("rst_op_cnt", 32'(op_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single uncontended operation from one requester, starting in IDLE.
  task automatic runOp(input string tag, input bit who, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [31:0] expRes, input bit expZero);
    @(posedge clk); #1;
    applyStimulus(who, a, b, op);
    @(negedge clk);
    checkOutput({tag, "_ready"}, 32'(who ? req1_ready : req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_exec_valid"}, 32'(rsp0_valid | rsp1_valid), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_rsp_valid"}, 32'(who ? rsp1_valid : rsp0_valid), 32'd1);
    checkOutput({tag, "_res"}, who ? rsp1_res : rsp0_res, expRes);
    checkOutput({tag, "_zero"}, 32'(who ? rsp1_zero : rsp0_zero), 32'(expZero));
    if (who) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    compared = 0; mismatched = 0; cycleCnt = 0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    doReset();

    // Single ADD from requester 0.
    runOp("t1_add", 1'b0, 32'd5, 32'd7, 4'd2, 32'd12, 1'b0);
    @(negedge clk);
    checkOutput("t1_op_cnt", 32'(op_cnt), 32'd1);

    // Contention right after reset: requester 0 wins first.
    doReset();
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'd3, 32'd3, 4'd6);
    applyStimulus(1'b1, 32'd1, 32'd2, 4'd7);
    @(negedge clk);
    checkOutput("t2_req0_ready", 32'(req0_ready), 32'd1);
    checkOutput("t2_req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    checkOutput("t2_exec_req1_ready", 32'(req1_ready), 32'd0);
    checkOutput("t2_exec_rsp1_valid", 32'(rsp1_valid), 32'd0);
    @(negedge clk);
    checkOutput("t2_rsp0_valid", 32'(rsp0_valid), 32'd1);
    checkOutput("t2_rsp1_valid", 32'(rsp1_valid), 32'd0);
    checkOutput("t2_rsp0_res", rsp0_res, 32'd0);
    checkOutput("t2_rsp0_zero", 32'(rsp0_zero), 32'd1);
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    @(negedge clk);
    checkOutput("t2_req1_ready_after", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t2_rsp1_valid_on", 32'(rsp1_valid), 32'd1);
    checkOutput("t2_rsp0_valid_off", 32'(rsp0_valid), 32'd0);
    checkOutput("t2_rsp1_res", rsp1_res, 32'd1);
    checkOutput("t2_rsp1_zero", 32'(rsp1_zero), 32'd0);
    rsp1_ready = 1'b1;
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    @(negedge clk);
    checkOutput("t2_op_cnt", 32'(op_cnt), 32'd2);

    // Response back-pressure with requester 1 waiting.
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'd9, 32'd4, 4'd6);
    @(negedge clk);
    checkOutput("t4_req0_ready", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    applyStimulus(1'b1, 32'd10, 32'd20, 4'd7);
    @(negedge clk);
    checkOutput("t4_exec_req1_ready", 32'(req1_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t4_hold%0d_valid", i), 32'(rsp0_valid), 32'd1);
      checkOutput($sformatf("t4_hold%0d_res", i), rsp0_res, 32'd5);
      checkOutput($sformatf("t4_hold%0d_alu_a", i), alu_a, 32'd9);
      checkOutput($sformatf("t4_hold%0d_alu_b", i), alu_b, 32'd4);
      checkOutput($sformatf("t4_hold%0d_alu_op", i), 32'(alu_op), 32'd6);
      checkOutput($sformatf("t4_hold%0d_req1_ready", i), 32'(req1_ready), 32'd0);
    end
    rsp0_ready = 1'b1;
    #1;
    checkOutput("t4_hs_req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    @(negedge clk);
    checkOutput("t4_req1_ready_after", 32'(req1_ready), 32'd1);
    checkOutput("t4_req0_ready_after", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t4_rsp1_valid", 32'(rsp1_valid), 32'd1);
    checkOutput("t4_rsp1_res", rsp1_res, 32'd1);
    rsp1_ready = 1'b1;
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    @(negedge clk);
    checkOutput("t4_op_cnt", 32'(op_cnt), 32'd4);

    // Both requesters always valid: strict alternation, 3 cycles per op.
    doReset();
    grantWho.delete();
    grantCyc.delete();
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'd1, 32'd1, 4'd2);
    applyStimulus(1'b1, 32'd2, 32'd2, 4'd2);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int c = 0; c < 60 && grantWho.size() < 8; c++) begin
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checkOutput("t3_grant_count", 32'(grantWho.size()), 32'd8);
    for (int i = 0; i < grantWho.size() && i < 8; i++) begin
      checkOutput($sformatf("t3_grant%0d", i), 32'(grantWho[i]), 32'(i % 2));
      if (i > 0)
        checkOutput($sformatf("t3_spacing%0d", i), 32'(grantCyc[i] - grantCyc[i-1]), 32'd3);
    end
    repeat (3) @(posedge clk);
    #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);
    checkOutput("t3_op_cnt", 32'(op_cnt), 32'd8);

    // Reset pulse while an operation is in EXEC.
    doReset();
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'd1, 32'd1, 4'd2);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_alu_a", alu_a, 32'd0);
    checkOutput("t5_alu_op", 32'(alu_op), 32'd0);
    checkOutput("t5_rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("t5_op_cnt", 32'(op_cnt), 32'd0);
    #1;
    rst_n = 1'b1;
    sawRsp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      sawRsp = sawRsp | rsp0_valid | rsp1_valid;
    end
    checkOutput("t5_no_rsp", 32'(sawRsp), 32'd0);
    checkOutput("t5_op_cnt_after", 32'(op_cnt), 32'd0);
    runOp("t5_add", 1'b0, 32'd2, 32'd3, 4'd2, 32'd5, 1'b0);
    @(negedge clk);
    checkOutput("t5_op_cnt_done", 32'(op_cnt), 32'd1);

    // Counter wrap: 14 more ops reach the all-ones value, one more wraps to 0.
    for (int i = 0; i < 14; i++)
      runOp($sformatf("t6_op%0d", i), i[0], 32'(i * 3), 32'd100, 4'd2, 32'(i * 3 + 100), 1'b0);
    @(negedge clk);
    checkOutput("t6_op_cnt_max", 32'(op_cnt), 32'd15);
    runOp("t6_last", 1'b1, 32'h8000_0000, 32'h8000_0000, 4'd2, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("t6_op_cnt_wrap", 32'(op_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
